// File: rtl/traffic_light_ctrl_multi.sv
// traffic_light_ctrl_multi: N-direction traffic-light controller with
// demand-driven round-robin arbitration, gap-out, rest-in-green, all-red
// clearance and a flashing-red maintenance mode. Outputs are a Moore decode
// of the registered state, direction index, timer and flash phase.
module traffic_light_ctrl_multi #(
    parameter int unsigned N_DIR       = 4,
    parameter int unsigned GREEN_TIME  = 10,
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned FLASH_HALF  = 2,
    parameter int unsigned TW          = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_DIR-1:0]           req,
    input  logic                       flash_mode,
    output logic [N_DIR-1:0]           red,
    output logic [N_DIR-1:0]           yellow,
    output logic [N_DIR-1:0]           green,
    output logic [$clog2(N_DIR)-1:0]   active_dir,
    output logic                       green_start
);

    localparam int unsigned DW = $clog2(N_DIR);

    localparam logic [TW-1:0] G_LAST = TW'(GREEN_TIME - 1);
    localparam logic [TW-1:0] G_MIN  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] A_LAST = TW'(ALLRED_TIME - 1);
    localparam logic [TW-1:0] F_LAST = TW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_FLASH
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   d, d_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            phase, phase_nxt;

    logic [N_DIR-1:0] d_oh;
    logic             others;
    logic [DW-1:0]    rr_dir;
    logic [DW-1:0]    idx;
    logic             found;

    assign d_oh   = N_DIR'(1) << d;
    assign others = |(req & ~d_oh);

    // Round-robin pick: first requesting direction after d, wrapping; d+1 if none.
    always_comb begin
        rr_dir = DW'((32'(d) + 32'd1) % N_DIR);
        idx    = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= N_DIR; k++) begin
            idx = DW'((32'(d) + k) % N_DIR);
            if (!found && req[idx]) begin
                rr_dir = idx;
                found  = 1'b1;
            end
        end
    end

    // State, direction, timer and flash-phase registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ALLRED;
            d     <= DW'(N_DIR - 1);
            timer <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            d     <= d_nxt;
            timer <= timer_nxt;
            phase <= phase_nxt;
        end
    end

    // Next-state logic; flash_mode overrides everything and is honoured even when en=0.
    always_comb begin
        state_nxt = state;
        d_nxt     = d;
        timer_nxt = timer;
        phase_nxt = phase;
        if (flash_mode && state != ST_FLASH) begin
            state_nxt = ST_FLASH;
            timer_nxt = '0;
            phase_nxt = 1'b0;
        end else if (!flash_mode && state == ST_FLASH) begin
            state_nxt = ST_ALLRED;
            timer_nxt = '0;
            phase_nxt = 1'b0;
        end else if (en) begin
            case (state)
                ST_GREEN: begin
                    if (others && (timer == G_LAST || (timer >= G_MIN && !req[d]))) begin
                        state_nxt = ST_YELLOW;
                        timer_nxt = '0;
                    end else if (timer != G_LAST) begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_YELLOW: begin
                    if (timer == Y_LAST) begin
                        state_nxt = ST_ALLRED;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_ALLRED: begin
                    if (timer == A_LAST) begin
                        state_nxt = ST_GREEN;
                        d_nxt     = rr_dir;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    if (timer == F_LAST) begin
                        timer_nxt = '0;
                        phase_nxt = ~phase;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
            endcase
        end
    end

    // Moore lamp decode from registered state only.
    always_comb begin
        red         = '0;
        yellow      = '0;
        green       = '0;
        active_dir  = d;
        green_start = 1'b0;
        case (state)
            ST_GREEN: begin
                green       = d_oh;
                red         = ~d_oh;
                green_start = (timer == '0);
            end
            ST_YELLOW: begin
                yellow = d_oh;
                red    = ~d_oh;
            end
            ST_ALLRED: begin
                red = '1;
            end
            default: begin
                red = phase ? '0 : '1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl_multi.sv
// Testbench for traffic_light_ctrl_multi: expected lamp frames are queued as
// stimulus is applied and compared cycle by cycle as the DUT produces them;
// safety invariants are checked on every sampled cycle.
module tb_traffic_light_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       flash_mode = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic       green_start;

    traffic_light_ctrl_multi #(
        .N_DIR       (4),
        .GREEN_TIME  (10),
        .MIN_GREEN   (4),
        .YELLOW_TIME (3),
        .ALLRED_TIME (1),
        .FLASH_HALF  (2),
        .TW          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .flash_mode  (flash_mode),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .active_dir  (active_dir),
        .green_start (green_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [14:0] w;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam int K_G    = 0;
    localparam int K_Y    = 1;
    localparam int K_R    = 2;
    localparam int K_FON  = 3;
    localparam int K_FOFF = 4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed frame {red, yellow, green, green_start, active_dir}.
    function automatic logic [14:0] frame(input int kind, input int dir, input bit gs);
        logic [3:0] oh;
        logic [3:0] r, y, g;
        oh = 4'b0001 << dir;
        r  = 4'b0000;
        y  = 4'b0000;
        g  = 4'b0000;
        case (kind)
            K_G:      begin g = oh; r = ~oh; end
            K_Y:      begin y = oh; r = ~oh; end
            K_R, K_FON: r = 4'hF;
            default:  ;
        endcase
        return {r, y, g, gs, 2'(dir)};
    endfunction

    function automatic logic [14:0] observed();
        return {red, yellow, green, green_start, active_dir};
    endfunction

    task automatic expect_run(input string tag, input int kind, input int dir, input int n, input bit gs_first);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag;
            e.w   = frame(kind, dir, gs_first && (i == 0));
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check(e.tag, 32'(observed()), 32'(e.w));
        end
    endtask

    // Called just after a falling edge: asserts reset away from any clock edge,
    // checks the asynchronous response, then releases before the next rising edge.
    task automatic do_reset(input logic [3:0] r);
        #2;
        rst        = 1'b0;
        req        = r;
        en         = 1'b1;
        flash_mode = 1'b0;
        #1;
        check("rst_async", 32'(observed()), 32'(frame(K_R, 3, 1'b0)));
        @(negedge clk);
        check("rst_hold", 32'(observed()), 32'(frame(K_R, 3, 1'b0)));
        #2;
        rst = 1'b1;
    endtask

    // Safety invariants on every sampled cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            check("inv_green_onehot", 32'($countones(green) <= 1), 32'd1);
            check("inv_yellow_onehot", 32'($countones(yellow) <= 1), 32'd1);
            check("inv_one_lamp",
                  32'(((red | yellow | green) == 4'h0) ||
                      (((red ^ yellow ^ green) == 4'hF) &&
                       (((red & yellow) | (red & green) | (yellow & green)) == 4'h0))),
                  32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset release with no demand: one all-red cycle, then rest in green 0.
        do_reset(4'b0000);
        expect_run("t1_rest_green0", K_G, 0, 50, 1'b1);
        drain();

        // Constant demand on 0 and 2: full-length greens alternate.
        do_reset(4'b0101);
        expect_run("t2_green0", K_G, 0, 10, 1'b1);
        expect_run("t2_yellow0", K_Y, 0, 3, 1'b0);
        expect_run("t2_allred0", K_R, 0, 1, 1'b0);
        expect_run("t2_green2", K_G, 2, 10, 1'b1);
        expect_run("t2_yellow2", K_Y, 2, 3, 1'b0);
        expect_run("t2_allred2", K_R, 2, 1, 1'b0);
        expect_run("t2_green0_again", K_G, 0, 1, 1'b1);
        drain();

        // Gap-out: own demand drops, other waiting -> green ends after MIN_GREEN.
        do_reset(4'b0001);
        expect_run("t3_green0_start", K_G, 0, 1, 1'b1);
        drain();
        req = 4'b0010;
        expect_run("t3_green0", K_G, 0, 3, 1'b0);
        expect_run("t3_yellow0", K_Y, 0, 3, 1'b0);
        expect_run("t3_allred0", K_R, 0, 1, 1'b0);
        expect_run("t3_green1", K_G, 1, 1, 1'b1);
        drain();

        // Wrap-around from direction 3 with demand on 0 and 2.
        do_reset(4'b1000);
        expect_run("t4a_green3_start", K_G, 3, 1, 1'b1);
        drain();
        req = 4'b0101;
        expect_run("t4a_green3", K_G, 3, 3, 1'b0);
        expect_run("t4a_yellow3", K_Y, 3, 3, 1'b0);
        expect_run("t4a_allred3", K_R, 3, 1, 1'b0);
        expect_run("t4a_green0", K_G, 0, 1, 1'b1);
        drain();

        // Wrap-around from direction 3 with no demand in the last all-red cycle.
        do_reset(4'b1000);
        expect_run("t4b_green3_start", K_G, 3, 1, 1'b1);
        drain();
        req = 4'b0001;
        expect_run("t4b_green3", K_G, 3, 3, 1'b0);
        expect_run("t4b_yellow3", K_Y, 3, 3, 1'b0);
        expect_run("t4b_allred3", K_R, 3, 1, 1'b0);
        drain();
        req = 4'b0000;
        expect_run("t4b_green0", K_G, 0, 1, 1'b1);
        drain();

        // Flash mode entered mid-green, then released.
        do_reset(4'b0101);
        expect_run("t5_green0", K_G, 0, 3, 1'b1);
        drain();
        flash_mode = 1'b1;
        expect_run("t5_flash_on", K_FON, 0, 2, 1'b0);
        expect_run("t5_flash_off", K_FOFF, 0, 2, 1'b0);
        expect_run("t5_flash_on2", K_FON, 0, 2, 1'b0);
        expect_run("t5_flash_off2", K_FOFF, 0, 2, 1'b0);
        drain();
        flash_mode = 1'b0;
        expect_run("t5_allred", K_R, 0, 1, 1'b0);
        expect_run("t5_green2", K_G, 2, 1, 1'b1);
        drain();

        // Enable dropped mid-yellow: outputs freeze, yellow still spans 3 enabled cycles.
        expect_run("t6_green2", K_G, 2, 9, 1'b0);
        expect_run("t6_yellow2_first", K_Y, 2, 1, 1'b0);
        drain();
        en = 1'b0;
        expect_run("t6_yellow2_frozen", K_Y, 2, 5, 1'b0);
        drain();
        en = 1'b1;
        expect_run("t6_yellow2_rest", K_Y, 2, 2, 1'b0);
        expect_run("t6_allred2", K_R, 2, 1, 1'b0);
        expect_run("t6_green0", K_G, 0, 1, 1'b1);
        drain();

        // Asynchronous reset mid-yellow, then recovery.
        expect_run("t6_green0_run", K_G, 0, 9, 1'b0);
        expect_run("t6_yellow0", K_Y, 0, 1, 1'b0);
        drain();
        do_reset(4'b0000);
        expect_run("t6_after_reset", K_G, 0, 1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
